// File: rtl/spi_slave_regbank.sv
// spi_slave_regbank: oversampled mode-0 SPI responder with a write/read register bank.
// Frames are [R/W][addr][data], MSB first; writes commit only on a clean deselect.
module spi_slave_regbank #(
  parameter int AWIDTH = 7,
  parameter int DWIDTH = 16,
  parameter int NREGS  = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    sen,
  input  logic                    sclk,
  input  logic                    mosi,
  output logic                    miso,
  output logic                    busy,
  output logic                    wr_stb,
  output logic [AWIDTH-1:0]       wr_addr,
  output logic [DWIDTH-1:0]       wr_data,
  output logic                    rd_stb,
  output logic                    frame_err,
  output logic [NREGS*DWIDTH-1:0] regs_out
);
  localparam int FRAME = 1 + AWIDTH + DWIDTH;
  localparam int CW = $clog2(FRAME + 2);
  localparam logic [CW-1:0] C_AW = CW'(AWIDTH);
  localparam logic [CW-1:0] C_LAST = CW'(FRAME - 1);
  localparam logic [CW-1:0] C_FRAME = CW'(FRAME);
  localparam logic [CW-1:0] C_SAT = CW'(FRAME + 1);
  typedef enum logic [1:0] {IDLE, HDR, DATA, OVER} state_t;
  state_t state_q, state_d;
  logic [1:0] sen_sync_q, sen_sync_d, mosi_sync_q, mosi_sync_d;
  logic [2:0] sclk_sync_q, sclk_sync_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [AWIDTH:0] hdr_q, hdr_d, hdr_n;
  logic [DWIDTH-1:0] din_q, din_d, sout_q, sout_d, pd_q, pd_d, wr_data_q, wr_data_d, rd_val;
  logic [AWIDTH-1:0] pa_q, pa_d, wr_addr_q, wr_addr_d;
  logic miso_q, miso_d, pend_wr_q, pend_wr_d, pend_rd_q, pend_rd_d, pend_err_q, pend_err_d;
  logic wr_stb_q, wr_stb_d;
  logic [DWIDTH-1:0] regs_q [NREGS];
  logic [DWIDTH-1:0] regs_d [NREGS];
  logic sen_s, mosi_s, rise, fall;
  assign sen_s = sen_sync_q[1];
  assign mosi_s = mosi_sync_q[1];
  assign rise = sclk_sync_q[1] & ~sclk_sync_q[2];
  assign fall = ~sclk_sync_q[1] & sclk_sync_q[2];
  always_comb begin
    sen_sync_d = {sen_sync_q[0], sen};
    sclk_sync_d = {sclk_sync_q[1:0], sclk};
    mosi_sync_d = {mosi_sync_q[0], mosi};
    state_d = state_q;
    cnt_d = cnt_q;
    hdr_d = hdr_q;
    din_d = din_q;
    sout_d = sout_q;
    miso_d = sen_s ? 1'b0 : miso_q;
    pend_wr_d = 1'b0;
    pend_rd_d = 1'b0;
    pend_err_d = 1'b0;
    pa_d = pa_q;
    pd_d = pd_q;
    wr_stb_d = pend_wr_q;
    wr_addr_d = pend_wr_q ? pa_q : wr_addr_q;
    wr_data_d = pend_wr_q ? pd_q : wr_data_q;
    regs_d = regs_q;
    hdr_n = {hdr_q[AWIDTH-1:0], mosi_s};
    rd_val = '0;
    for (int i = 0; i < NREGS; i++) begin
      if (hdr_n[AWIDTH-1:0] == AWIDTH'(i)) rd_val = regs_q[i];
      if (pend_wr_q && pa_q == AWIDTH'(i)) regs_d[i] = pd_q;
    end
    if (state_q == IDLE) begin
      if (!sen_s) begin
        state_d = HDR;
        cnt_d = '0;
      end
    end else if (sen_s) begin
      // deselect outranks any SCLK edge seen in the same cycle
      state_d = IDLE;
      cnt_d = '0;
      pend_wr_d = cnt_q == C_FRAME && !hdr_q[AWIDTH];
      pend_rd_d = cnt_q == C_FRAME && hdr_q[AWIDTH];
      pend_err_d = cnt_q != C_FRAME && cnt_q != '0;
      pa_d = hdr_q[AWIDTH-1:0];
      pd_d = din_q;
    end else if (rise) begin
      cnt_d = cnt_q == C_SAT ? cnt_q : cnt_q + 1'b1;
      if (state_q == HDR) begin
        hdr_d = hdr_n;
        if (cnt_q == C_AW) begin
          state_d = DATA;
          sout_d = rd_val;
        end
      end else if (state_q == DATA) begin
        din_d = {din_q[DWIDTH-2:0], mosi_s};
        if (cnt_q == C_LAST) state_d = OVER;
      end
    end else if (fall && state_q != HDR && hdr_q[AWIDTH]) begin
      miso_d = sout_q[DWIDTH-1];
      sout_d = {sout_q[DWIDTH-2:0], 1'b0};
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sen_sync_q <= 2'b11;
      sclk_sync_q <= '0;
      mosi_sync_q <= '0;
      state_q <= IDLE;
      cnt_q <= '0;
      hdr_q <= '0;
      din_q <= '0;
      sout_q <= '0;
      miso_q <= 1'b0;
      pend_wr_q <= 1'b0;
      pend_rd_q <= 1'b0;
      pend_err_q <= 1'b0;
      pa_q <= '0;
      pd_q <= '0;
      wr_stb_q <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
    end else begin
      sen_sync_q <= sen_sync_d;
      sclk_sync_q <= sclk_sync_d;
      mosi_sync_q <= mosi_sync_d;
      state_q <= state_d;
      cnt_q <= cnt_d;
      hdr_q <= hdr_d;
      din_q <= din_d;
      sout_q <= sout_d;
      miso_q <= miso_d;
      pend_wr_q <= pend_wr_d;
      pend_rd_q <= pend_rd_d;
      pend_err_q <= pend_err_d;
      pa_q <= pa_d;
      pd_q <= pd_d;
      wr_stb_q <= wr_stb_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      regs_q <= regs_d;
    end
  end
  always_comb begin
    regs_out = '0;
    for (int i = 0; i < NREGS; i++) regs_out[i*DWIDTH +: DWIDTH] = regs_q[i];
  end
  assign miso = miso_q & ~sen_s;
  assign busy = ~sen_s;
  assign wr_stb = wr_stb_q;
  assign wr_addr = wr_addr_q;
  assign wr_data = wr_data_q;
  assign rd_stb = pend_rd_q;
  assign frame_err = pend_err_q;
endmodule

// File: tb/tb_spi_slave_regbank.sv
// tb_spi_slave_regbank: directed frame table, mid-frame reset and random frames
// checked against an array model of the register bank.
module tb_spi_slave_regbank;
  localparam int AW = 7;
  localparam int DW = 16;
  localparam int NR = 8;
  logic clk = 1'b0;
  logic rst, sen, sclk, mosi;
  logic miso, busy, wr_stb, rd_stb, frame_err;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic [NR*DW-1:0] regs_out;
  spi_slave_regbank #(.AWIDTH(AW), .DWIDTH(DW), .NREGS(NR)) dut (
    .clk(clk), .rst(rst), .sen(sen), .sclk(sclk), .mosi(mosi), .miso(miso), .busy(busy),
    .wr_stb(wr_stb), .wr_addr(wr_addr), .wr_data(wr_data), .rd_stb(rd_stb),
    .frame_err(frame_err), .regs_out(regs_out)
  );
  always #5 clk = ~clk;
  int n_chk = 0;
  int n_fail = 0;
  int c_wr = 0;
  int c_rd = 0;
  int c_err = 0;
  always @(negedge clk) begin
    if (wr_stb) c_wr++;
    if (rd_stb) c_rd++;
    if (frame_err) c_err++;
  end
  logic [DW-1:0] model [NR];
  logic [AW-1:0] m_wa;
  logic [DW-1:0] m_wd;
  typedef struct {
    logic [31:0] bits;
    int n;
    int e_wr;
    int e_rd;
    int e_err;
    logic [15:0] e_rdata;
    int idx;
    logic [15:0] val;
  } vec_t;
  vec_t tbl [9];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic model_reset();
    for (int i = 0; i < NR; i++) model[i] = '0;
    m_wa = '0;
    m_wd = '0;
  endtask
  // Reference behaviour: only a full-length frame does anything; short/long frames flag an error.
  task automatic model_frame(input logic [31:0] bits, input int n, output int e_wr, output int e_rd,
                             output int e_err, output logic [15:0] e_rdata);
    int a;
    a = int'(bits[22:16]);
    e_wr = (n == 24 && !bits[23]) ? 1 : 0;
    e_rd = (n == 24 && bits[23]) ? 1 : 0;
    e_err = (n != 0 && n != 24) ? 1 : 0;
    e_rdata = (a < NR) ? model[a] : 16'h0;
    if (e_wr == 1) begin
      m_wa = bits[22:16];
      m_wd = bits[15:0];
      if (a < NR) model[a] = bits[15:0];
    end
  endtask
  task automatic send_bits(input logic [31:0] bits, input int n, input int lo, input int hi,
                           inout logic [15:0] rdata);
    for (int i = lo; i < hi; i++) begin
      mosi = bits[n-1-i];
      repeat (4) @(negedge clk);
      if (i >= 8 && i < 24) rdata = {rdata[14:0], miso};
      sclk = 1'b1;
      repeat (4) @(negedge clk);
      sclk = 1'b0;
    end
  endtask
  task automatic do_frame(input logic [31:0] bits, input int n, output int d_wr, output int d_rd,
                          output int d_err, output logic [15:0] rdata);
    int w0, r0, e0;
    w0 = c_wr;
    r0 = c_rd;
    e0 = c_err;
    rdata = '0;
    sen = 1'b0;
    repeat (4) @(negedge clk);
    send_bits(bits, n, 0, n, rdata);
    repeat (4) @(negedge clk);
    sen = 1'b1;
    repeat (12) @(negedge clk);
    d_wr = c_wr - w0;
    d_rd = c_rd - r0;
    d_err = c_err - e0;
  endtask
  task automatic check_state(input string tag);
    for (int i = 0; i < NR; i++) chk($sformatf("%s reg%0d", tag, i), 32'(regs_out[i*DW +: DW]), 32'(model[i]));
    chk({tag, " wr_addr"}, 32'(wr_addr), 32'(m_wa));
    chk({tag, " wr_data"}, 32'(wr_data), 32'(m_wd));
    chk({tag, " miso idle"}, 32'(miso), 32'h0);
    chk({tag, " busy idle"}, 32'(busy), 32'h0);
  endtask
  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
  initial begin
    int d_wr, d_rd, d_err, e_wr, e_rd, e_err;
    logic [15:0] rdata, e_rdata;
    logic [31:0] bits;
    int n;
    tbl[0] = '{32'h051234, 24, 1, 0, 0, 16'h0, 5, 16'h1234};
    tbl[1] = '{32'h850000, 24, 0, 1, 0, 16'h1234, 5, 16'h1234};
    tbl[2] = '{32'h03ABC, 20, 0, 0, 1, 16'h0, 5, 16'h1234};
    tbl[3] = '{32'h0A5A5A5, 25, 0, 0, 1, 16'h0, 2, 16'h0};
    tbl[4] = '{32'h02BEEF, 24, 1, 0, 0, 16'h0, 2, 16'hBEEF};
    tbl[5] = '{32'h105555, 24, 1, 0, 0, 16'h0, 5, 16'h1234};
    tbl[6] = '{32'h900000, 24, 0, 1, 0, 16'h0000, 2, 16'hBEEF};
    tbl[7] = '{32'h0, 0, 0, 0, 0, 16'h0, 5, 16'h1234};
    tbl[8] = '{32'h820000, 24, 0, 1, 0, 16'hBEEF, 2, 16'hBEEF};
    rst = 1'b1;
    sen = 1'b1;
    sclk = 1'b0;
    mosi = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    chk("reset wr_stb", 32'(wr_stb), 32'h0);
    chk("reset frame_err", 32'(frame_err), 32'h0);
    check_state("reset");
    rst = 1'b0;
    repeat (5) @(negedge clk);
    check_state("post-reset");
    for (int t = 0; t < 9; t++) begin
      do_frame(tbl[t].bits, tbl[t].n, d_wr, d_rd, d_err, rdata);
      model_frame(tbl[t].bits, tbl[t].n, e_wr, e_rd, e_err, e_rdata);
      chk($sformatf("tbl%0d wr_stb count", t), 32'(d_wr), 32'(tbl[t].e_wr));
      chk($sformatf("tbl%0d rd_stb count", t), 32'(d_rd), 32'(tbl[t].e_rd));
      chk($sformatf("tbl%0d frame_err count", t), 32'(d_err), 32'(tbl[t].e_err));
      if (tbl[t].e_rd == 1) chk($sformatf("tbl%0d read data", t), 32'(rdata), 32'(tbl[t].e_rdata));
      chk($sformatf("tbl%0d reg%0d", t, tbl[t].idx), 32'(regs_out[tbl[t].idx*DW +: DW]), 32'(tbl[t].val));
      check_state($sformatf("tbl%0d", t));
    end
    // reset after 10 bits of a write, then finish the frame: stub is an error, nothing written
    bits = 32'h03AAAA;
    rdata = '0;
    d_wr = c_wr;
    sen = 1'b0;
    repeat (4) @(negedge clk);
    send_bits(bits, 24, 0, 10, rdata);
    rst = 1'b1;
    model_reset();
    repeat (3) @(negedge clk);
    check_state("midreset");
    rst = 1'b0;
    d_err = c_err;
    send_bits(bits, 24, 10, 24, rdata);
    repeat (4) @(negedge clk);
    sen = 1'b1;
    repeat (12) @(negedge clk);
    chk("midreset frame_err count", 32'(c_err - d_err), 32'h1);
    chk("midreset wr_stb count", 32'(c_wr - d_wr), 32'h0);
    check_state("midreset end");
    for (int r = 0; r < 40; r++) begin
      n = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 30)) : 24;
      bits = $urandom;
      bits[23] = $urandom_range(0, 1) == 1;
      bits[22:16] = 7'($urandom_range(0, 11));
      do_frame(bits, n, d_wr, d_rd, d_err, rdata);
      model_frame(bits, n, e_wr, e_rd, e_err, e_rdata);
      chk($sformatf("rnd%0d wr_stb count", r), 32'(d_wr), 32'(e_wr));
      chk($sformatf("rnd%0d rd_stb count", r), 32'(d_rd), 32'(e_rd));
      chk($sformatf("rnd%0d frame_err count", r), 32'(d_err), 32'(e_err));
      if (e_rd == 1) chk($sformatf("rnd%0d read data", r), 32'(rdata), 32'(e_rdata));
      check_state($sformatf("rnd%0d", r));
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
